// File: rtl/hopfield_core_param_if.sv
// Command/status bus of the Hopfield core: command strobe, pattern, status and weight readback.
interface hopfield_core_param_if #(
  parameter int N  = 7,
  parameter int WW = 8
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic          start;
  logic [1:0]    mode;
  logic [N-1:0]  pattern_in;
  logic          busy;
  logic          done;
  logic          converged;
  logic [N-1:0]  state_out;
  logic [7:0]    sweeps;
  logic [AW-1:0] w_row;
  logic [AW-1:0] w_col;
  logic [WW-1:0] w_rd;

  modport master (
    output start, mode, pattern_in, w_row, w_col,
    input  busy, done, converged, state_out, sweeps, w_rd
  );

  modport slave (
    input  start, mode, pattern_in, w_row, w_col,
    output busy, done, converged, state_out, sweeps, w_rd
  );
endinterface

// File: rtl/hopfield_core_param.sv
// Parametrised Hopfield associative memory: saturating Hebbian learn, clear, and
// sequential (asynchronous-update) recall with convergence detection and a sweep limit.
module hopfield_core_param #(
  parameter int N          = 7,
  parameter int WW         = 8,
  parameter int MAX_SWEEPS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  hopfield_core_param_if.slave bus
);
  localparam int AW   = (N > 1) ? $clog2(N) : 1;
  localparam int ACCW = WW + AW + 1;
  localparam logic signed [WW-1:0]   W_MAX    = {1'b0, {(WW-1){1'b1}}};
  localparam logic signed [WW-1:0]   W_MIN    = -W_MAX;
  localparam logic signed [WW-1:0]   W_ONE    = {{(WW-1){1'b0}}, 1'b1};
  localparam logic signed [ACCW-1:0] ACC_ZERO = {ACCW{1'b0}};
  localparam logic [AW-1:0]          LAST     = AW'(N - 1);
  localparam logic [7:0]             SWEEP_LIM = 8'(MAX_SWEEPS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEARN  = 3'd1,
    S_CLEAR  = 3'd2,
    S_ACCUM  = 3'd3,
    S_UPDATE = 3'd4
  } state_t;

  state_t                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_conv;
  logic                   r_changed;
  logic [N-1:0]           r_s;
  logic [N-1:0]           r_pat;
  logic [7:0]             r_sweeps;
  logic [AW-1:0]          r_i;
  logic [AW-1:0]          r_j;
  logic signed [ACCW-1:0] r_acc;
  logic signed [WW-1:0]   r_w [N][N];

  logic signed [WW-1:0]   w_wij;
  logic signed [ACCW-1:0] w_wext;
  logic signed [ACCW-1:0] w_term;
  logic                   w_new_s;
  logic                   w_any_flip;
  logic [7:0]             w_sweeps_inc;
  logic [WW-1:0]          w_rd;

  function automatic logic signed [WW-1:0] sat_step(input logic signed [WW-1:0] w,
                                                    input logic                 up);
    logic signed [WW-1:0] r;
    if (up) r = (w >= W_MAX) ? W_MAX : w + W_ONE;
    else    r = (w <= W_MIN) ? W_MIN : w - W_ONE;
    return r;
  endfunction

  // Recall datapath: signed term for neuron j, threshold decision and flip tracking.
  always_comb begin
    w_wij        = r_w[r_i][r_j];
    w_wext       = {{(ACCW-WW){w_wij[WW-1]}}, w_wij};
    w_term       = r_s[r_j] ? w_wext : -w_wext;
    if (r_acc > ACC_ZERO)      w_new_s = 1'b1;
    else if (r_acc < ACC_ZERO) w_new_s = 1'b0;
    else                       w_new_s = r_s[r_i];
    w_any_flip   = r_changed | (w_new_s != r_s[r_i]);
    w_sweeps_inc = r_sweeps + 8'd1;
  end

  // Weight readback; out-of-range addresses read as zero.
  always_comb begin
    if ((int'(bus.w_row) < N) && (int'(bus.w_col) < N)) w_rd = r_w[bus.w_row][bus.w_col];
    else                                                 w_rd = {WW{1'b0}};
  end

  assign bus.w_rd      = w_rd;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.converged = r_conv;
  assign bus.state_out = r_s;
  assign bus.sweeps    = r_sweeps;

  // Command FSM, weight matrix and recall engine.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_conv    <= 1'b0;
      r_changed <= 1'b0;
      r_s       <= {N{1'b0}};
      r_pat     <= {N{1'b0}};
      r_sweeps  <= 8'd0;
      r_i       <= {AW{1'b0}};
      r_j       <= {AW{1'b0}};
      r_acc     <= ACC_ZERO;
      for (int a = 0; a < N; a++)
        for (int b = 0; b < N; b++)
          r_w[a][b] <= {WW{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.mode)
              2'b00: begin
                r_s       <= bus.pattern_in;
                r_sweeps  <= 8'd0;
                r_i       <= {AW{1'b0}};
                r_j       <= {AW{1'b0}};
                r_acc     <= ACC_ZERO;
                r_changed <= 1'b0;
                r_conv    <= 1'b0;
                r_busy    <= 1'b1;
                r_state   <= S_ACCUM;
              end
              2'b01: begin
                r_pat   <= bus.pattern_in;
                r_i     <= {AW{1'b0}};
                r_conv  <= 1'b0;
                r_busy  <= 1'b1;
                r_state <= S_LEARN;
              end
              2'b10: begin
                r_conv  <= 1'b0;
                r_busy  <= 1'b1;
                r_state <= S_CLEAR;
              end
              default: r_state <= S_IDLE;
            endcase
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LEARN: begin
          // Diagonal is skipped; rows are written symmetrically over the full pass.
          for (int j = 0; j < N; j++)
            if (j != int'(r_i))
              r_w[r_i][j] <= sat_step(r_w[r_i][j], r_pat[r_i] ~^ r_pat[j]);
          if (r_i == LAST) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_i <= r_i + AW'(1);
          end
        end
        S_CLEAR: begin
          for (int a = 0; a < N; a++)
            for (int b = 0; b < N; b++)
              r_w[a][b] <= {WW{1'b0}};
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        S_ACCUM: begin
          r_acc <= r_acc + w_term;
          if (r_j == LAST) begin
            r_j     <= {AW{1'b0}};
            r_state <= S_UPDATE;
          end else begin
            r_j <= r_j + AW'(1);
          end
        end
        S_UPDATE: begin
          r_s[r_i] <= w_new_s;
          r_acc    <= ACC_ZERO;
          if (r_i == LAST) begin
            r_sweeps <= w_sweeps_inc;
            if (!w_any_flip || (w_sweeps_inc == SWEEP_LIM)) begin
              r_conv  <= ~w_any_flip;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_changed <= 1'b0;
              r_i       <= {AW{1'b0}};
              r_state   <= S_ACCUM;
            end
          end else begin
            r_changed <= w_any_flip;
            r_i       <= r_i + AW'(1);
            r_state   <= S_ACCUM;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/hopfield_core_param.md
# hopfield_core_param

Parametrised Hopfield associative-memory core: N binary neurons, on-chip signed saturating Hebbian weight matrix, sequential recall engine. Successor to the fixed 7-neuron network. Adds generic neuron count and weight width, three command modes (learn, recall, clear), a start/busy/done handshake, convergence detection, a sweep limit and a weight readback port. Sits between the pattern source (pads or host) and the spike/state outputs.

## Interface
- N, 7: number of neurons (2..16).
- WW, 8: signed weight width; weights saturate at ±(2^(WW-1)-1).
- MAX_SWEEPS, 8: recall sweep limit (1..255).
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  2  sampled with start: 00 recall, 01 learn, 10 clear weights, 11 no-op (ignored).
- pattern_in  in  N  bipolar pattern; bit 1 = +1, bit 0 = -1; sampled with start.
- busy  out  1  high while a command executes.
- done  out  1  one-cycle pulse at command completion.
- converged  out  1  valid from done of a recall until next start; 1 = last sweep had no flips.
- state_out  out  N  current neuron states (spikes).
- sweeps  out  8  sweeps executed by last recall.
- w_row, w_col  in  clog2(N) each  weight readback address.
- w_rd  out  WW  combinational w[w_row][w_col]; 0 if either index ≥ N.

## Operation
- States: IDLE, LEARN, CLEAR, ACCUM, UPDATE.
- Reset: all weights 0, state_out 0, busy 0, done 0, converged 0, sweeps 0, FSM IDLE.
- Diagonal w[i][i] always 0, never written; matrix is kept symmetric.
- IDLE + start: mode 00 → state_out←pattern_in, sweeps←0, neuron i←0, j←0, acc←0 → ACCUM. Mode 01 → latch pattern, row i←0 → LEARN. Mode 10 → CLEAR. Mode 11 → remain IDLE, no busy/done.
- LEARN: one row per cycle. For row i, every j≠i: w[i][j] += (p_i XNOR p_j) ? +1 : -1, saturating. After row N-1 → IDLE.
- CLEAR: all weights ←0 in one cycle → IDLE.
- ACCUM: one term per cycle, j = 0..N-1: acc += state_out[j] ? w[i][j] : -w[i][j]. acc is signed, WW+clog2(N)+1 bits, so it never overflows. Uses live state_out, so updates are asynchronous Hopfield style.
- UPDATE: acc>0 → s_i←1; acc<0 → s_i←0; acc==0 → s_i unchanged. A flip sets the sweep_changed flag. Then i++, acc←0, back to ACCUM.
- End of sweep (UPDATE of i=N-1): sweeps++.
  - No flips in the sweep → converged←1, finish.
  - Else if sweeps == MAX_SWEEPS → converged←0, finish.
  - Else clear sweep_changed, i←0, next sweep.
- start, mode and pattern_in are ignored while busy. reset_n low mid-command aborts to the reset state; partial learn updates are lost (all weights cleared).

## Timing
- Let E be the edge where start is sampled in IDLE. busy=1 from E.
- Learn: row i written at edge E+1+i. At edge E+N: busy←0, done←1. done←0 at E+N+1.
- Clear: weights zeroed at edge E+1; busy←0, done←1 at the same edge.
- Recall:
  - state_out loaded at E.
  - Each neuron takes N+1 cycles; neuron i of sweep k (k from 0) is updated at edge E+(k·N+i+1)(N+1).
  - done, busy←0 and converged/sweeps are updated at the same edge as the final UPDATE: E+S·N·(N+1) for S sweeps.
- The earliest new start is the cycle done is high (FSM already IDLE).
- w_rd is combinational from registered weights; reflects a write on the cycle after it.

## Test plan
- Reset mid-recall (reset_n low ~20 cycles after start) → every output returns to 0 immediately; w_rd reads 0 everywhere; a following learn+recall behaves normally.
- N=7: clear, learn 1010101, recall with 1010100 → sweep 1 restores bit 0, sweep 2 has no flips; state_out=1010101, converged=1, sweeps=2, done at E+2·56=E+112.
- Learn 1100000 exactly 130 times with WW=8 → w[0][1]=127, w[0][2]=-127, w[1][0]=127, w[i][i]=0.
- Recall after clear with pattern 0110011 → all fields 0, no flips; state_out unchanged, converged=1, sweeps=1, done at E+56.
- MAX_SWEEPS=1: learn 1111111, recall 1111100 → converged=0, sweeps=1; state_out=1111111 after one sweep.
- Start pulses with mode 01 while a recall is busy → ignored: weights unchanged and exactly one done pulse. Mode 11 in IDLE → no busy, no done.
